// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline sequencer of the 5-stage MIPS core:
//   seq_state_e      - sequencer FSM encoding (RUN / MEM_WAIT)
//   REG_ZERO         - register number of $zero, which never carries a hazard
//   load_use_hazard  - load-use detection between the ID and EX stages
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } seq_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load in EX whose destination is read by the instruction in ID.
   // Writes to $zero are discarded, so they can never create a dependency.
   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       id_uses_rt
   );
      return ex_mem_read & (ex_rt != REG_ZERO) &
             ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high clear
//   inc_i  - count one event this cycle
//   cnt_o  - current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: hold once saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
// Pipeline sequencer for the 5-stage MIPS core. Resolves, in priority order:
//   1. data memory not ready (freeze the whole pipeline, with timeout)
//   2. taken branch / jump from MEM (redirect PC, flush IF/ID, ID/EX, EX/MEM)
//   3. load-use hazard (hold PC and IF/ID, inject one bubble into ID/EX)
// Control outputs are combinational (Mealy); counters and mem_err registered.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt         - source operands of the ID instruction
//   ex_mem_read, ex_rt               - load in EX and its destination
//   mem_branch, mem_zero, mem_jump   - control-flow resolution in MEM
//   mem_access, mem_ready            - data memory handshake
//   pc_write, pc_sel                 - PC enable and next-PC mux select
//   *_write, *_flush                 - pipeline buffer enables / bubble inserts
//   mem_err                          - sticky memory timeout flag
//   stall_cnt, flush_cnt             - saturating performance counters
// -----------------------------------------------------------------------------
module hazard_sequencer
   import pipe_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_jump,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             memwb_write,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   seq_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;

   logic              lu_haz_s;
   logic              redir_s;
   logic              mwait_s;
   logic [WAIT_W-1:0] wait_next_s;
   logic              stall_inc_s;
   logic              flush_inc_s;

   assign lu_haz_s = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
   assign redir_s  = (mem_branch & mem_zero) | mem_jump;
   // Once a timeout has been flagged the memory is treated as ready so the
   // core can keep running until software/reset deals with it.
   assign mwait_s  = mem_access & ~mem_ready & ~mem_err_q;

   // Wait-cycle count the current frozen cycle will represent.
   always_comb begin
      wait_next_s = WAIT_ONE;
      case (state_q)
         RUN:      wait_next_s = WAIT_ONE;
         MEM_WAIT: wait_next_s = wait_cnt_q + WAIT_ONE;
         default:  wait_next_s = WAIT_ONE;
      endcase
   end

   // Next-state and Mealy control outputs; later overrides take priority.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
      pc_write    = 1'b1;
      pc_sel      = 1'b0;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      exmem_flush = 1'b0;
      memwb_write = 1'b1;

      // Normal decode; a redirect flushes the hazarding instruction anyway.
      if (redir_s) begin
         pc_sel      = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         flush_inc_s = 1'b1;
      end else if (lu_haz_s) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         stall_inc_s = 1'b1;
      end else begin
         pc_sel      = 1'b0;
      end

      // Memory wait freezes everything, regardless of FSM state.
      if (mwait_s) begin
         pc_write    = 1'b0;
         pc_sel      = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b0;
         idex_write  = 1'b0;
         idex_flush  = 1'b0;
         exmem_write = 1'b0;
         exmem_flush = 1'b0;
         memwb_write = 1'b0;
         flush_inc_s = 1'b0;
         stall_inc_s = 1'b1;
         if (wait_next_s == WAIT_LIMIT) begin
            mem_err_d  = 1'b1;
            state_d    = RUN;
            wait_cnt_d = WAIT_ZERO;
         end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = wait_next_s;
         end
      end else begin
         state_d    = RUN;
         wait_cnt_d = WAIT_ZERO;
      end

      // Reset holds the pipeline empty: no loads, bubbles everywhere.
      if (rst) begin
         pc_write    = 1'b0;
         pc_sel      = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_write  = 1'b0;
         idex_flush  = 1'b1;
         exmem_write = 1'b0;
         exmem_flush = 1'b1;
         memwb_write = 1'b0;
         stall_inc_s = 1'b0;
         flush_inc_s = 1'b0;
      end else begin
         memwb_write = memwb_write;
      end
   end

   // FSM, wait counter and sticky error register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= WAIT_ZERO;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (stall_inc_s),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (flush_inc_s),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed table-driven bench for hazard_sequencer plus hand-written
// multi-cycle sequences (memory wait, timeout, reset mid-stall, saturation).
// Control word order: {pc_write, pc_sel, ifid_write, ifid_flush, idex_write,
//                      idex_flush, exmem_write, exmem_flush, memwb_write}
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

   localparam logic [8:0] O_NORM   = 9'b101010101;
   localparam logic [8:0] O_LU     = 9'b000011101;
   localparam logic [8:0] O_REDIR  = 9'b111111111;
   localparam logic [8:0] O_FREEZE = 9'b000000000;
   localparam logic [8:0] O_RST    = 9'b000101010;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_uses_rt, ex_mem_read;
   logic        mem_branch, mem_zero, mem_jump, mem_access, mem_ready;
   logic        pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush;
   logic        exmem_write, exmem_flush, memwb_write, mem_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic [8:0]  outs;

   int n_pass;
   int n_total;
   int exp_stall;
   int exp_flush;

   typedef struct packed {
      logic       mr;
      logic [4:0] ex_rt;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       uses_rt;
      logic       br;
      logic       zero;
      logic       jmp;
      logic       acc;
      logic       rdy;
      logic [8:0] exp;
      logic       ds;
      logic       df;
   } vec_t;

   vec_t vecs [13];

   hazard_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .mem_branch  (mem_branch),
      .mem_zero    (mem_zero),
      .mem_jump    (mem_jump),
      .mem_access  (mem_access),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .pc_sel      (pc_sel),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .idex_write  (idex_write),
      .idex_flush  (idex_flush),
      .exmem_write (exmem_write),
      .exmem_flush (exmem_flush),
      .memwb_write (memwb_write),
      .mem_err     (mem_err),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   assign outs = {pc_write, pc_sel, ifid_write, ifid_flush, idex_write,
                  idex_flush, exmem_write, exmem_flush, memwb_write};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_rt = 5'd0;
      mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
      mem_access = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr();
      tick();
      rst = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      ex_mem_read = v.mr; ex_rt = v.ex_rt; id_rs = v.id_rs; id_rt = v.id_rt;
      id_uses_rt = v.uses_rt; mem_branch = v.br; mem_zero = v.zero;
      mem_jump = v.jmp; mem_access = v.acc; mem_ready = v.rdy;
   endtask

   initial begin
      n_pass = 0; n_total = 0; exp_stall = 0; exp_flush = 0;

      //            mr    ex_rt  id_rs  id_rt  use   br    zero  jmp   acc   rdy   exp      ds    df
      vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,    1'b1, 1'b0};
      vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,    1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd8,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_REDIR, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};
      vecs[8]  = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_REDIR, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 5'd8,  5'd8,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_REDIR, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM,  1'b0, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_REDIR, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM,  1'b0, 1'b0};

      // Reset: outputs forced even with a taken branch on the inputs.
      rst = 1'b1;
      clr();
      mem_branch = 1'b1; mem_zero = 1'b1;
      #1;
      chk("rst_outputs", 32'(outs), 32'(O_RST));
      tick();
      tick();
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      rst = 1'b0;
      clr();

      // Single-cycle vector table, each applied from RUN.
      for (int i = 0; i < 13; i++) begin
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d_outputs", i), 32'(outs), 32'(vecs[i].exp));
         exp_stall += int'(vecs[i].ds);
         exp_flush += int'(vecs[i].df);
         tick();
         chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
         chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(exp_flush));
      end

      // Load-use: one bubble, then the bubble in EX no longer reads memory.
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1;
      chk("lu_cycle1", 32'(outs), 32'(O_LU));
      tick();
      ex_mem_read = 1'b0;
      #1;
      chk("lu_cycle2", 32'(outs), 32'(O_NORM));
      tick();
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // Memory wait of 3 cycles; a redirect during the wait is ignored.
      do_reset();
      mem_access = 1'b1; mem_ready = 1'b0;
      #1;
      chk("mw_cycle1", 32'(outs), 32'(O_FREEZE));
      tick();
      mem_jump = 1'b1;
      #1;
      chk("mw_cycle2_jump", 32'(outs), 32'(O_FREEZE));
      tick();
      mem_jump = 1'b0;
      #1;
      chk("mw_cycle3", 32'(outs), 32'(O_FREEZE));
      tick();
      chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);
      mem_ready = 1'b1;
      #1;
      chk("mw_release", 32'(outs), 32'(O_NORM));
      tick();
      chk("mw_stall_after", 32'(stall_cnt), 32'd3);
      chk("mw_flush_cnt", 32'(flush_cnt), 32'd0);

      // Timeout: 15 frozen cycles, then mem_err and the pipeline resumes.
      do_reset();
      mem_access = 1'b1; mem_ready = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         #1;
         chk($sformatf("to_freeze%0d", k), 32'(outs), 32'(O_FREEZE));
         tick();
         if (k == 14) begin
            chk("to_err_before", 32'(mem_err), 32'd0);
         end
      end
      chk("to_err_set", 32'(mem_err), 32'd1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'd15);
      #1;
      chk("to_resume", 32'(outs), 32'(O_NORM));
      tick();
      chk("to_err_sticky", 32'(mem_err), 32'd1);
      chk("to_stall_hold", 32'(stall_cnt), 32'd15);
      rst = 1'b1;
      #1;
      chk("to_rst_outputs", 32'(outs), 32'(O_RST));
      tick();
      rst = 1'b0;
      chk("to_err_cleared", 32'(mem_err), 32'd0);
      #1;
      chk("to_wait_again", 32'(outs), 32'(O_FREEZE));
      tick();

      // Reset in the middle of a wait leaves nothing behind.
      do_reset();
      mem_access = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_outputs", 32'(outs), 32'(O_RST));
      tick();
      rst = 1'b0;
      mem_access = 1'b0;
      #1;
      chk("mid_rst_resume", 32'(outs), 32'(O_NORM));
      chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();

      // Saturation of the stall counter.
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      repeat (65540) tick();
      chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
      chk("sat_flush_cnt", 32'(flush_cnt), 32'd0);
      clr();
      mem_access = 1'b1; mem_ready = 1'b0;
      repeat (3) tick();
      chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
